// File: rtl/nebula_fifo_wr_arb.sv
// nebula_fifo_wr_arb: round-robin arbiter sharing one nebula_fifo push port among NUM_REQ requesters
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_req_valid/i_req_data requester beats, requester i data in [i*WIDTH +: WIDTH]
//   i_req_last             last beat of a packet (used only with NEBULA_ARB_LOCK_EN)
//   o_req_ready            one-hot or zero accept strobe
//   o_fifo_push/o_fifo_din drive FIFO push/din; i_fifo_full from FIFO full
//   o_grant_valid/o_grant_id current selection (id 0 when none)
//   o_push_cnt             running count of accepted beats, wraps at 16 bits
// Macro NEBULA_ARB_LOCK_EN: hold the grant on one requester until its req_last beat.
module nebula_fifo_wr_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 16,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]       i_req_last,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic                     o_fifo_push,
  output logic [WIDTH-1:0]         o_fifo_din,
  input  logic                     i_fifo_full,
  output logic                     o_grant_valid,
  output logic [IDW-1:0]           o_grant_id,
  output logic [15:0]              o_push_cnt
);
  logic [IDW-1:0]   r_rr_ptr;
  logic [15:0]      r_push_cnt;
  logic [IDW-1:0]   w_rr_sel;
  logic [IDW:0]     w_idx;
  logic [IDW-1:0]   w_sel;
  logic [IDW-1:0]   w_owner;
  logic             w_locked;
  logic             w_eog;
  logic             w_gv;
  logic             w_push;
  logic [WIDTH-1:0] w_din;
  // Search downward so the candidate closest to r_rr_ptr is written last and wins.
  always_comb begin
    w_rr_sel = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NUM_REQ)) w_idx = w_idx - (IDW+1)'(NUM_REQ);
      if (i_req_valid[w_idx[IDW-1:0]]) w_rr_sel = w_idx[IDW-1:0];
    end
  end
  assign w_sel  = w_locked ? w_owner : w_rr_sel;
  // Reset gates the combinational outputs so nothing leaks while rst_n is low.
  assign w_gv   = i_rst_n & (w_locked ? i_req_valid[w_owner] : |i_req_valid);
  assign w_push = w_gv & ~i_fifo_full;
  always_comb begin
    w_din = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_sel == IDW'(i)) w_din = i_req_data[i*WIDTH +: WIDTH];
  end
  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_ready
    assign o_req_ready[g] = w_push & (w_sel == IDW'(g));
  end
  assign o_fifo_push   = w_push;
  assign o_fifo_din    = w_gv ? w_din : '0;
  assign o_grant_valid = w_gv;
  assign o_grant_id    = w_gv ? w_sel : '0;
  assign o_push_cnt    = r_push_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_push_cnt <= '0;
    end else if (w_push) begin
      r_push_cnt <= r_push_cnt + 16'd1;
      if (w_eog) r_rr_ptr <= (w_sel == IDW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
    end
`ifdef NEBULA_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_owner, w_owner_nxt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    if (w_push) begin
      w_state_nxt = i_req_last[w_sel] ? IDLE : LOCKED;
      w_owner_nxt = w_sel;
    end
  end
  assign w_locked = (r_state == LOCKED);
  assign w_owner  = r_owner;
  assign w_eog    = i_req_last[w_sel];
`else
  logic w_unused_last;
  assign w_unused_last = ^i_req_last;
  assign w_locked = 1'b0;
  assign w_owner  = '0;
  assign w_eog    = 1'b1;
`endif
endmodule

// File: doc/nebula_fifo_wr_arb.md
# nebula_fifo_wr_arb

Round-robin write-side arbiter that shares one `nebula_fifo` push port among `NUM_REQ` requesters using per-requester valid/ready handshakes. It selects one requester per cycle, forwards its data to the FIFO when the FIFO is not full, and advances a rotating priority pointer after each accepted beat. Optional packet locking keeps a grant on one requester until that requester's last beat. It sits directly in front of the FIFO's `push`/`din`/`full` pins in router input and ejection paths.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..16.
- `WIDTH`, default 16: data width, which must match the FIFO `WIDTH`.
- `IDW`, derived as `$clog2(NUM_REQ)`: width of the grant index.
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `req_valid`, in, NUM_REQ: per-requester beat valid.
- `req_data`, in, NUM_REQ*WIDTH: requester i's data is in slice `[i*WIDTH +: WIDTH]`.
- `req_last`, in, NUM_REQ: marks the last beat of a packet. It is used only when locking is compiled in.
- `req_ready`, out, NUM_REQ: one-hot or zero; beat accepted when `req_valid[i] & req_ready[i]`.
- `fifo_push`, out, 1: drives the FIFO `push` pin.
- `fifo_din`, out, WIDTH: drives the FIFO `din` pin.
- `fifo_full`, in, 1: from the FIFO `full` pin.
- `grant_valid`, out, 1: a requester is currently selected.
- `grant_id`, out, IDW: index of the selected requester; 0 when `grant_valid` is 0.
- `push_cnt`, out, 16: running count of accepted beats.

## Operation
- Registered state:
  - `rr_ptr` (IDW): the highest-priority index.
  - `state`: IDLE or LOCKED.
  - `owner` (IDW).
  - `push_cnt`.
- Selection in IDLE: `sel` is the first i with `req_valid[i]=1`, searching rr_ptr, rr_ptr+1, … mod NUM_REQ. `grant_valid = |req_valid`.
- Selection in LOCKED: `sel = owner` and `grant_valid = req_valid[owner]`. Other requesters never see ready.
- Ready and push:
  - `req_ready[i] = grant_valid & (i==sel) & ~fifo_full`.
  - `fifo_push = grant_valid & ~fifo_full`.
  - `fifo_din = req_data[sel]`, or 0 when `grant_valid=0`.
- On a transfer (`fifo_push=1`):
  - `push_cnt` increments, wrapping 0xFFFF→0.
  - If it is an end-of-grant beat: `rr_ptr <= (sel+1) mod NUM_REQ`, computed as a compare-and-wrap and correct for non-power-of-2 NUM_REQ. `state <= IDLE`.
  - Otherwise (lock mode, `req_last[sel]=0`): `state <= LOCKED`, `owner <= sel`, and `rr_ptr` is unchanged.
- No transfer: all state holds, including when full or when all valid bits are low.
- `fifo_full=1`: no ready, no push, no pointer movement, and the selection stays visible on `grant_id`.
- Owner drops valid while LOCKED: stay LOCKED, insert a bubble, and do not serve other requesters.
- Reset mid-packet: lock dropped, `state=IDLE`, `rr_ptr=0`.
- While `rst_n=0`: `req_ready`, `fifo_push`, `grant_valid` and `grant_id` are forced to 0, `fifo_din` is 0, and `push_cnt` is 0.

## Timing
- Zero-cycle request-to-push: the path from `req_valid`/`fifo_full` to `fifo_push`/`req_ready` is combinational from registered state plus inputs.
- Throughput is one beat per cycle while the FIFO is not full.
- The state update is visible the cycle after the transfer; the next cycle's search starts from the new `rr_ptr`.
- `fifo_full` is used as sampled in the current cycle. A pop in the same cycle that frees space is not anticipated.
- Fairness: with all requesters valid and no back-pressure, each requester is served within NUM_REQ grants (in packets when locked).

## Configuration
- `NEBULA_ARB_LOCK_EN` defined:
  - IDLE/LOCKED FSM active.
  - A grant persists from the first beat through the beat with `req_last=1`.
  - A single-beat packet (first beat has `last=1`) never enters LOCKED.
- Undefined:
  - `req_last` is ignored and `state` is tied to IDLE.
  - Every transfer is end-of-grant, so arbitration interleaves per beat.

## Test plan
- Reset, then all four requesters valid with data 0xA0..0xA3, `fifo_full=0` → pushes 0xA0, 0xA1, 0xA2, 0xA3, 0xA0 on consecutive cycles; `push_cnt=5`.
- Only requester 2 valid for 3 cycles, then requesters 0 and 3 valid → grants 2,2,2, then 3 (rr_ptr=3), then 0.
- `fifo_full=1` for 4 cycles with requester 1 valid → `fifo_push=0`, `req_ready=0`, `grant_id=1` held; push occurs on the first cycle `full=0`.
- With lock enabled: requester 0 sends a 3-beat packet (last on beat 3) while requester 1 is valid → beats 0,0,0 then 1. Requester 0 dropping valid on beat 2 inserts a bubble; requester 1 is not granted.
- Assert `rst_n=0` asynchronously mid-packet (LOCKED, rr_ptr=2) → outputs are 0 immediately; after release, rr_ptr=0 and IDLE, and requester 1 can win.
- Drive 65537 transfers → `push_cnt` wraps to 1.
